// File: rtl/eic_top.sv
`default_nettype none
// ============================================================================
// Module      : eic_top
// Description : Minimal firmware sequencer that fetches 32-bit command words
//               from internal RAM and drives one GPIO pin. Optional macro
//               ILLEGAL_TRAP_EN makes undefined opcodes halt the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module eic_top #(
    parameter int MEM_WORDS = 4096,
    parameter     INIT_FILE = ""
) (
    input  logic clk_50M,
    input  logic ext_reset,
    output logic gpio
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    reg [31:0] memory [0:MEM_WORDS-1];

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [AW-1:0] pc;
    logic [31:0]   ir;
    logic [23:0]   cnt;

    logic [3:0]    op;
    logic          wait_go;
    logic          halt_go;
    logic          ir_load;
    logic          pc_inc;
    logic          pc_load;
    logic          gpio_set;
    logic          gpio_tgl;
    logic          cnt_load;
    logic          cnt_dec;
    logic          unused_bits;

    assign op          = ir[31:28];
    assign unused_bits = ^ir[27:24];

    always_ff @(posedge clk_50M or posedge ext_reset) begin
        if (ext_reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                if (halt_go)      state_nxt = S_HALT;
                else if (wait_go) state_nxt = S_WAIT;
                else              state_nxt = S_FETCH;
            end
            S_WAIT:  if (cnt == 24'd1) state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Unknown (X) opcodes fall through to the default arm and behave as NOP.
    always_comb begin
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        gpio_set = 1'b0;
        gpio_tgl = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        wait_go  = 1'b0;
        halt_go  = 1'b0;
        case (state)
            S_FETCH: ir_load = 1'b1;
            S_EXEC: begin
                case (op)
                    4'h1: begin
                        gpio_set = 1'b1;
                        pc_inc   = 1'b1;
                    end
                    4'h2: begin
                        if (ir[23:0] == 24'd0) begin
                            pc_inc = 1'b1;
                        end else begin
                            cnt_load = 1'b1;
                            wait_go  = 1'b1;
                        end
                    end
                    4'h3: pc_load = 1'b1;
                    4'h4: begin
                        gpio_tgl = 1'b1;
                        pc_inc   = 1'b1;
                    end
                    4'hF: halt_go = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE:
                        halt_go = 1'b1;
`endif
                    default: pc_inc = 1'b1;
                endcase
            end
            S_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt == 24'd1) pc_inc = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50M or posedge ext_reset) begin
        if (ext_reset) begin
            pc   <= '0;
            ir   <= 32'd0;
            cnt  <= 24'd0;
            gpio <= 1'b0;
        end else begin
            if (ir_load)       ir  <= memory[pc];
            if (pc_load)       pc  <= ir[AW-1:0];
            else if (pc_inc)   pc  <= pc + 1'b1;
            if (cnt_load)      cnt <= ir[23:0];
            else if (cnt_dec)  cnt <= cnt - 24'd1;
            // SET only consumes bit 0, so an X elsewhere in the word cannot reach the pin.
            if (gpio_set)      gpio <= ir[0];
            else if (gpio_tgl) gpio <= ~gpio;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eic_top.sv
`default_nettype none
// Directed testbench for eic_top: small programs preloaded into RAM, gpio/pc
// checked edge by edge against hand-derived timelines.
module tb_eic_top;

    localparam int MW = 16;

    logic clk_50M;
    logic ext_reset;
    logic gpio;

    int total;
    int bad;

    eic_top #(.MEM_WORDS(MW), .INIT_FILE("")) dut (
        .clk_50M   (clk_50M),
        .ext_reset (ext_reset),
        .gpio      (gpio)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    task automatic clear_mem();
        for (int i = 0; i < MW; i++) dut.memory[i] = 32'h0000_0000;
    endtask

    task automatic hold_reset();
        @(negedge clk_50M);
        ext_reset = 1'b1;
        @(negedge clk_50M);
    endtask

    task automatic release_reset();
        @(negedge clk_50M);
        ext_reset = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic test_reset();
        hold_reset();
        clear_mem();
        edges(2);
        total++;
        if (gpio !== 1'b0) begin
            bad++;
            $display("FAIL reset_gpio: got %b want 0", gpio);
        end
        total++;
        if (dut.pc !== 4'd0) begin
            bad++;
            $display("FAIL reset_pc: got %0d want 0", dut.pc);
        end
    endtask

    task automatic test_set_halt();
        hold_reset();
        clear_mem();
        dut.memory[0] = 32'h1000_0001;
        dut.memory[1] = 32'hF000_0000;
        release_reset();
        edges(1);
        total++;
        if (gpio !== 1'b0) begin
            bad++;
            $display("FAIL set_halt_edge1: got %b want 0", gpio);
        end
        edges(1);
        total++;
        if (gpio !== 1'b1) begin
            bad++;
            $display("FAIL set_halt_edge2: got %b want 1", gpio);
        end
        edges(20);
        total++;
        if (gpio !== 1'b1) begin
            bad++;
            $display("FAIL set_halt_hold: got %b want 1", gpio);
        end
        total++;
        if (dut.pc !== 4'd1) begin
            bad++;
            $display("FAIL set_halt_pc: got %0d want 1", dut.pc);
        end
        // Reset while halted must clear gpio without a clock edge.
        @(negedge clk_50M);
        ext_reset = 1'b1;
        #1;
        total++;
        if (gpio !== 1'b0) begin
            bad++;
            $display("FAIL halt_async_reset: got %b want 0", gpio);
        end
    endtask

    task automatic test_wait();
        int high;
        logic exp;
        hold_reset();
        clear_mem();
        dut.memory[0] = 32'h1000_0001;
        dut.memory[1] = 32'h2000_000A;
        dut.memory[2] = 32'h1000_0000;
        dut.memory[3] = 32'hF000_0000;
        release_reset();
        high = 0;
        for (int k = 1; k <= 24; k++) begin
            edges(1);
            exp = (k >= 2 && k < 16);
            if (gpio === 1'b1) high++;
            total++;
            if (gpio !== exp) begin
                bad++;
                $display("FAIL wait_edge%0d: got %b want %b", k, gpio, exp);
            end
        end
        total++;
        if (high != 14) begin
            bad++;
            $display("FAIL wait_high_cycles: got %0d want 14", high);
        end
    endtask

    task automatic test_toggle();
        logic exp;
        hold_reset();
        clear_mem();
        dut.memory[0] = 32'h4000_0000;
        dut.memory[1] = 32'h3000_0000;
        release_reset();
        for (int k = 1; k <= 24; k++) begin
            edges(1);
            exp = (k >= 2) ? (((k - 2) / 4) % 2 == 0) : 1'b0;
            total++;
            if (gpio !== exp) begin
                bad++;
                $display("FAIL toggle_edge%0d: got %b want %b", k, gpio, exp);
            end
        end
    endtask

    task automatic test_wrap();
        int       chk_edge [6] = '{1, 2, 33, 34, 65, 66};
        logic     chk_val  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int       now;
        hold_reset();
        clear_mem();
        dut.memory[0] = 32'h4000_0000;
        release_reset();
        now = 0;
        for (int i = 0; i < 6; i++) begin
            edges(chk_edge[i] - now);
            now = chk_edge[i];
            total++;
            if (gpio !== chk_val[i]) begin
                bad++;
                $display("FAIL wrap_edge%0d: got %b want %b", now, gpio, chk_val[i]);
            end
            if (now == 2) begin
                edges(30);
                now = 32;
                total++;
                if (dut.pc !== 4'd0) begin
                    bad++;
                    $display("FAIL wrap_pc_edge32: got %0d want 0", dut.pc);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic exp4;
`ifdef ILLEGAL_TRAP_EN
        exp4 = 1'b0;
`else
        exp4 = 1'b1;
`endif
        hold_reset();
        clear_mem();
        dut.memory[0] = 32'h5000_0000;
        dut.memory[1] = 32'h1000_0001;
        dut.memory[2] = 32'hF000_0000;
        release_reset();
        edges(3);
        total++;
        if (gpio !== 1'b0) begin
            bad++;
            $display("FAIL illegal_edge3: got %b want 0", gpio);
        end
        edges(1);
        total++;
        if (gpio !== exp4) begin
            bad++;
            $display("FAIL illegal_edge4: got %b want %b", gpio, exp4);
        end
        edges(10);
        total++;
        if (gpio !== exp4) begin
            bad++;
            $display("FAIL illegal_hold: got %b want %b", gpio, exp4);
        end
`ifdef ILLEGAL_TRAP_EN
        total++;
        if (dut.pc !== 4'd0) begin
            bad++;
            $display("FAIL illegal_trap_pc: got %0d want 0", dut.pc);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        hold_reset();
        clear_mem();
        dut.memory[0] = 32'h1000_0001;
        dut.memory[1] = 32'h2000_03E8;
        dut.memory[2] = 32'hF000_0000;
        release_reset();
        edges(10);
        total++;
        if (gpio !== 1'b1 || dut.state !== 2'd2) begin
            bad++;
            $display("FAIL midwait_pre: gpio %b state %0d want 1 / 2", gpio, dut.state);
        end
        #4;
        ext_reset = 1'b1;
        #1;
        total++;
        if (gpio !== 1'b0 || dut.pc !== 4'd0) begin
            bad++;
            $display("FAIL midwait_async: gpio %b pc %0d want 0 / 0", gpio, dut.pc);
        end
        release_reset();
        edges(1);
        total++;
        if (gpio !== 1'b0) begin
            bad++;
            $display("FAIL midwait_restart_edge1: got %b want 0", gpio);
        end
        edges(1);
        total++;
        if (gpio !== 1'b1) begin
            bad++;
            $display("FAIL midwait_restart_edge2: got %b want 1", gpio);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        ext_reset = 1'b1;
        test_reset();
        test_set_halt();
        test_wait();
        test_toggle();
        test_wrap();
        test_illegal();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
